bp_nonsynth_mem_tester: RTL and testbench

- Nonsynthesizable BedRock memory-command initiator. It is the requester end of the lite cce_mem interface that the nonsynth memory model serves.
- Drives uncached block writes over a test region, then reads each block back and checks the response header and data against a deterministic pattern.
- Used in ME testbenches in place of a CCE/LCE to smoke-test the memory path: stream conversion, cce_to_cache, L2 and DRAM model.

---
 rtl/bp_me_nonsynth_pkg.sv | 70 +++++++
 rtl/bp_nonsynth_mem_tester_pattern.sv | 23 ++
 rtl/bp_nonsynth_mem_tester.sv | 151 +++++++++++++++
 tb/tb_bp_nonsynth_mem_tester.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_nonsynth_pkg.sv
// Shared types for the nonsynth memory tester: lite BedRock mem header layout,
// tester FSM states and the deterministic block data pattern.
package bp_me_nonsynth_pkg;

    localparam int paddr_width_gp     = 40;
    localparam int cce_block_width_gp = 512;
    localparam int lce_id_width_gp    = 4;
    localparam int lce_assoc_gp       = 8;
    localparam int block_bytes_gp     = cce_block_width_gp / 8;
    localparam int block_words_gp     = cce_block_width_gp / 64;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    localparam bp_bedrock_msg_size_e block_size_gp =
        bp_bedrock_msg_size_e'($clog2(block_bytes_gp));

    typedef struct packed {
        logic [$clog2(lce_assoc_gp)-1:0] way_id;
        logic [lce_id_width_gp-1:0]      lce_id;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_payload_s payload;
        bp_bedrock_msg_size_e    size;
        logic [paddr_width_gp-1:0] addr;
        bp_bedrock_mem_type_e    msg_type;
    } bp_bedrock_mem_header_s;

    typedef struct packed {
        logic [cce_block_width_gp-1:0] data;
        bp_bedrock_mem_header_s        header;
    } bp_bedrock_mem_msg_s;

    localparam int cce_mem_msg_width_gp = $bits(bp_bedrock_mem_msg_s);

    typedef enum logic [2:0] {
        e_reset,
        e_wr_send,
        e_wr_wait,
        e_rd_send,
        e_rd_wait,
        e_done
    } tester_state_e;

    function automatic logic [63:0] pattern_word(input logic [63:0] base,
                                                 input logic [63:0] seed,
                                                 input logic [31:0] k,
                                                 input logic [31:0] w);
        return (base + 64'(k) * 64'(block_bytes_gp) + 64'(w) * 64'd8) ^ seed;
    endfunction

endpackage

// File: rtl/bp_nonsynth_mem_tester_pattern.sv
// Expected block address and data for block index k; shared by the write
// path and the read-back check so both always agree.
module bp_nonsynth_mem_tester_pattern
    import bp_me_nonsynth_pkg::*;
#(
    parameter int          k_width_p   = 4,
    parameter logic [63:0] base_addr_p = 64'h8000_0000,
    parameter logic [63:0] seed_p      = 64'hDEAD_BEEF_0BAD_F00D
) (
    input  logic [k_width_p-1:0]          block_i,
    output logic [cce_block_width_gp-1:0] data_o,
    output logic [paddr_width_gp-1:0]     addr_o
);

    always_comb begin
        data_o = '0;
        for (int w = 0; w < block_words_gp; w++) begin
            data_o[w*64 +: 64] = pattern_word(base_addr_p, seed_p, 32'(block_i), 32'(w));
        end
        addr_o = paddr_width_gp'(base_addr_p + 64'(block_i) * 64'(block_bytes_gp));
    end

endmodule

// File: rtl/bp_nonsynth_mem_tester.sv
// Memory-path smoke tester: uncached block writes over a region, then reads
// each block back and counts header/data mismatches and timeouts.
module bp_nonsynth_mem_tester
    import bp_me_nonsynth_pkg::*;
#(
    parameter int          num_blocks_p = 16,
    parameter logic [63:0] base_addr_p  = 64'h8000_0000,
    parameter logic [63:0] seed_p       = 64'hDEAD_BEEF_0BAD_F00D,
    parameter int          timeout_p    = 100000
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    output logic [cce_mem_msg_width_gp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_and_i,
    input  logic [cce_mem_msg_width_gp-1:0] mem_resp_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [15:0]                     error_count_o
);

    localparam int k_width_lp = (num_blocks_p > 1) ? $clog2(num_blocks_p) : 1;
    localparam logic [k_width_lp-1:0] last_k_lp = k_width_lp'(num_blocks_p - 1);
    localparam logic [31:0] timeout_last_lp = 32'(timeout_p - 1);

    tester_state_e            state_q, state_d;
    logic [k_width_lp-1:0]    k_q, k_d;
    logic [31:0]              timer_q, timer_d;
    logic [15:0]              err_cnt_q, err_cnt_d;

    logic [cce_block_width_gp-1:0] pat_data;
    logic [paddr_width_gp-1:0]     pat_addr;
    bp_bedrock_mem_msg_s           cmd_msg;
    bp_bedrock_mem_msg_s           resp_msg;
    logic                          resp_bad;
    logic                          bump;
    logic                          yumi;

    bp_nonsynth_mem_tester_pattern #(
        .k_width_p  (k_width_lp),
        .base_addr_p(base_addr_p),
        .seed_p     (seed_p)
    ) pattern (
        .block_i(k_q),
        .data_o (pat_data),
        .addr_o (pat_addr)
    );

    assign resp_msg = bp_bedrock_mem_msg_s'(mem_resp_i);

    // Command is decoded purely from registered state and k, so it holds
    // steady for as long as the handshake is stalled.
    always_comb begin
        cmd_msg                     = '0;
        cmd_msg.header.msg_type     = (state_q == e_rd_send) ? e_bedrock_mem_uc_rd
                                                             : e_bedrock_mem_uc_wr;
        cmd_msg.header.addr         = pat_addr;
        cmd_msg.header.size         = block_size_gp;
        cmd_msg.data                = (state_q == e_wr_send) ? pat_data : '0;
    end

    always_comb begin
        resp_bad = (resp_msg.header.addr != pat_addr);
        if (state_q == e_wr_wait) begin
            resp_bad = resp_bad || (resp_msg.header.msg_type != e_bedrock_mem_uc_wr);
        end else begin
            resp_bad = resp_bad || (resp_msg.header.msg_type != e_bedrock_mem_uc_rd)
                                || (resp_msg.data != pat_data);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        timer_d = timer_q;
        bump    = 1'b0;
        yumi    = 1'b0;
        unique case (state_q)
            e_reset: state_d = e_wr_send;
            e_wr_send, e_rd_send: begin
                // Only one command is ever outstanding: a response now is stray.
                yumi = mem_resp_v_i;
                bump = mem_resp_v_i;
                if (mem_cmd_ready_and_i) begin
                    state_d = (state_q == e_wr_send) ? e_wr_wait : e_rd_wait;
                    timer_d = '0;
                end
            end
            e_wr_wait, e_rd_wait: begin
                yumi = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    bump = resp_bad;
                    if (k_q == last_k_lp) begin
                        if (state_q == e_wr_wait) begin
                            k_d     = '0;
                            state_d = e_rd_send;
                        end else begin
                            state_d = e_done;
                        end
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = (state_q == e_wr_wait) ? e_wr_send : e_rd_send;
                    end
                end else if (timer_q == timeout_last_lp) begin
                    bump    = 1'b1;
                    state_d = e_done;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            e_done: begin
                yumi = mem_resp_v_i;
                bump = mem_resp_v_i;
            end
            default: state_d = e_reset;
        endcase

        err_cnt_d = err_cnt_q;
        if (bump && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_reset;
            k_q       <= '0;
            timer_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            timer_q   <= timer_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mem_cmd_o       = cmd_msg;
    assign mem_cmd_v_o     = (state_q == e_wr_send) || (state_q == e_rd_send);
    assign mem_resp_yumi_o = yumi;
    assign done_o          = (state_q == e_done);
    assign error_count_o   = err_cnt_q;
    assign error_o         = (err_cnt_q != 16'd0);

endmodule

// File: tb/tb_bp_nonsynth_mem_tester.sv
// Bench for bp_nonsynth_mem_tester: a small memory responder, a queue of
// expected commands, table-driven scenarios and a few hand-written sequences.
module tb_bp_nonsynth_mem_tester;
    import bp_me_nonsynth_pkg::*;

    localparam int          nb_lp   = 4;
    localparam int          to_lp   = 50;
    localparam logic [63:0] base_lp = 64'h8000_0000;
    localparam logic [63:0] seed_lp = 64'hDEAD_BEEF_0BAD_F00D;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic [cce_mem_msg_width_gp-1:0] mem_cmd_o;
    logic                            mem_cmd_v_o;
    logic                            mem_cmd_ready_and_i = 1'b0;
    logic [cce_mem_msg_width_gp-1:0] mem_resp_i = '0;
    logic                            mem_resp_v_i = 1'b0;
    logic                            mem_resp_yumi_o;
    logic                            done_o;
    logic                            error_o;
    logic [15:0]                     error_count_o;

    always #5 clk = ~clk;

    bp_nonsynth_mem_tester #(
        .num_blocks_p(nb_lp),
        .base_addr_p (base_lp),
        .seed_p      (seed_lp),
        .timeout_p   (to_lp)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .mem_cmd_o          (mem_cmd_o),
        .mem_cmd_v_o        (mem_cmd_v_o),
        .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
        .mem_resp_i         (mem_resp_i),
        .mem_resp_v_i       (mem_resp_v_i),
        .mem_resp_yumi_o    (mem_resp_yumi_o),
        .done_o             (done_o),
        .error_o            (error_o),
        .error_count_o      (error_count_o)
    );

    typedef enum int {M_IDEAL, M_BACKP, M_CORRUPT, M_NORESP} mode_e;
    typedef struct {
        mode_e mode;
        int    exp_hs;
        int    exp_cnt;
        bit    exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    bp_bedrock_mem_msg_s     exp_q[$];
    logic [511:0]            mem_blk[nb_lp];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bp_bedrock_mem_msg_s exp_cmd(input int k, input bit rd);
        bp_bedrock_mem_msg_s m;
        logic [63:0] a;
        m = '0;
        a = base_lp + 64'(k) * 64'd64;
        m.header.msg_type = bp_bedrock_mem_type_e'(rd ? 4'd2 : 4'd3);
        m.header.addr     = a[39:0];
        m.header.size     = bp_bedrock_msg_size_e'(3'd6);
        if (!rd) begin
            for (int w = 0; w < 8; w++) begin
                m.data[w*64 +: 64] = (a + 64'(w) * 64'd8) ^ seed_lp;
            end
        end
        return m;
    endfunction

    task automatic fill_queue();
        exp_q.delete();
        for (int k = 0; k < nb_lp; k++) exp_q.push_back(exp_cmd(k, 1'b0));
        for (int k = 0; k < nb_lp; k++) exp_q.push_back(exp_cmd(k, 1'b1));
    endtask

    // Runs one full test pass against the responder; returns handshakes seen
    // and cycles from the last accepted command to done_o.
    task automatic run(input mode_e mode, input bit mid_reset, output int hs, output int lat);
        bp_bedrock_mem_msg_s pend, m, e, prev_cmd;
        bit  pend_v, have_prev, rst_req, rst_done, saw_done;
        int  pend_delay, acc_cyc, idx;
        fill_queue();
        reset_i = 1'b1;
        mem_cmd_ready_and_i = 1'b0;
        mem_resp_v_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        hs = 0; lat = -1; pend_v = 0; pend_delay = 0; pend = '0; prev_cmd = '0;
        have_prev = 0; rst_req = 0; rst_done = 0; acc_cyc = 0; saw_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (done_o) begin
                lat = cyc - acc_cyc;
                saw_done = 1;
                break;
            end
            if (rst_req) begin
                reset_i = 1'b1;
                mem_resp_v_i = 1'b1;
                mem_cmd_ready_and_i = 1'b1;
                @(negedge clk);
                check("rst_cmd_v", mem_cmd_v_o, 0);
                check("rst_yumi", mem_resp_yumi_o, 0);
                check("rst_done", done_o, 0);
                check("rst_err", error_o, 0);
                check("rst_cnt", error_count_o, 0);
                reset_i = 1'b0;
                mem_resp_v_i = 1'b0;
                pend_v = 0; have_prev = 0; rst_req = 0; rst_done = 1; hs = 0;
                fill_queue();
                continue;
            end
            mem_cmd_ready_and_i = (mode == M_BACKP) ? (cyc % 3 == 0) : 1'b1;
            if (pend_v && pend_delay == 0 && mode != M_NORESP) begin
                mem_resp_v_i = 1'b1;
                mem_resp_i   = pend;
            end else begin
                mem_resp_v_i = 1'b0;
            end
            if (pend_v && pend_delay > 0) pend_delay--;
            #1;
            if (mem_resp_v_i) begin
                check("resp_yumi", mem_resp_yumi_o, 1);
                pend_v = 0;
            end
            if (have_prev && mem_cmd_v_o) begin
                m = bp_bedrock_mem_msg_s'(mem_cmd_o);
                check("stall_hdr", 64'(m.header), 64'(prev_cmd.header));
                check_blk("stall_data", m.data, prev_cmd.data);
            end
            if (mem_cmd_v_o && mem_cmd_ready_and_i) begin
                hs++;
                m = bp_bedrock_mem_msg_s'(mem_cmd_o);
                if (exp_q.size() == 0) begin
                    check("extra_cmd", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_hdr", 64'(m.header), 64'(e.header));
                    check_blk("cmd_data", m.data, e.data);
                end
                idx = int'((m.header.addr - base_lp[39:0]) >> 6);
                pend = '0;
                pend.header = m.header;
                if (idx >= 0 && idx < nb_lp) begin
                    if (m.header.msg_type == bp_bedrock_mem_type_e'(4'd3)) begin
                        mem_blk[idx] = m.data;
                    end else begin
                        pend.data = mem_blk[idx];
                        if (mode == M_CORRUPT && idx == 2) pend.data[0] = ~pend.data[0];
                        if (mid_reset && !rst_done && idx == 1) rst_req = 1;
                    end
                end
                pend_v = 1; pend_delay = 2; acc_cyc = cyc;
                have_prev = 0;
            end else if (mem_cmd_v_o) begin
                have_prev = 1;
                prev_cmd  = bp_bedrock_mem_msg_s'(mem_cmd_o);
            end else begin
                have_prev = 0;
            end
        end
        mem_resp_v_i = 1'b0;
        mem_cmd_ready_and_i = 1'b0;
        if (!saw_done) check("done_budget", 0, 1);
        if (mid_reset) check("mid_reset_hit", 64'(rst_done), 1);
    endtask

    vec_t vecs[4];

    initial begin
        int hs, lat;
        vecs[0] = '{M_IDEAL,   8, 0, 1'b0};
        vecs[1] = '{M_BACKP,   8, 0, 1'b0};
        vecs[2] = '{M_CORRUPT, 8, 1, 1'b1};
        vecs[3] = '{M_NORESP,  1, 1, 1'b1};

        // Reset state while reset is held.
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_cmd_v", mem_cmd_v_o, 0);
        check("reset_done", done_o, 0);
        check("reset_err", error_o, 0);
        check("reset_cnt", error_count_o, 0);

        for (int i = 0; i < 4; i++) begin
            run(vecs[i].mode, 1'b0, hs, lat);
            check($sformatf("v%0d_hs", i), 64'(hs), 64'(vecs[i].exp_hs));
            check($sformatf("v%0d_done", i), done_o, 1);
            check($sformatf("v%0d_cnt", i), error_count_o, 64'(vecs[i].exp_cnt));
            check($sformatf("v%0d_err", i), error_o, 64'(vecs[i].exp_err));
            if (vecs[i].mode == M_NORESP) check("timeout_latency", 64'(lat), 64'(to_lp + 1));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_idle_v", i), mem_cmd_v_o, 0);
        end

        // Stray response while done: consumed immediately and counted.
        run(M_IDEAL, 1'b0, hs, lat);
        check("done_cnt0", error_count_o, 0);
        @(negedge clk);
        mem_resp_v_i = 1'b1;
        #1;
        check("done_yumi", mem_resp_yumi_o, 1);
        @(negedge clk);
        mem_resp_v_i = 1'b0;
        check("done_cnt1", error_count_o, 1);
        check("done_err1", error_o, 1);
        check("done_still", done_o, 1);

        // Reset during the read wait of block 1, then a clean full pass.
        run(M_IDEAL, 1'b1, hs, lat);
        check("midrst_hs", 64'(hs), 8);
        check("midrst_done", done_o, 1);
        check("midrst_cnt", error_count_o, 0);

        // Stray response while a command is still waiting for ready.
        reset_i = 1'b1;
        mem_cmd_ready_and_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        check("send_cmd_v", mem_cmd_v_o, 1);
        mem_resp_v_i = 1'b1;
        #1;
        check("send_yumi", mem_resp_yumi_o, 1);
        @(negedge clk);
        mem_resp_v_i = 1'b0;
        check("send_cnt", error_count_o, 1);
        check("send_cmd_held", mem_cmd_v_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
